scalar_mult7: RTL

Left-to-right double-and-add controller computing k·P on the GF(2^7) binary curve. It sits directly upstream of the point-arithmetic datapath and feeds it operands. It sequences one doubling or one addition at a time into the point-op engine over a load/done handshake, and tracks the point at infinity itself. Points use the codebase packing throughout: bits [6:0] = x, bits [13:7] = y.

---
 rtl/scalar_mult7.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/scalar_mult7.sv
// scalar_mult7 -- left-to-right double-and-add controller for k*P on the
// GF(2^7) binary curve. It issues one doubling or one addition at a time to an
// external point-op engine and tracks the point at infinity itself.
// Point packing: bits [6:0] = x, bits [13:7] = y.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, sampled only when idle
//   scalar, point       k and P, latched with an accepted start
//   busy                high from the cycle after acceptance until done
//   done                one-cycle pulse when result/result_inf are valid
//   result, result_inf  k*P and its infinity flag, held until the next start
//   op_load             one-cycle pulse launching an engine operation
//   op_sel              0 = double op_a, 1 = add op_a + op_b
//   op_a, op_b          engine operands, held from op_load until op_done
//   op_result, op_inf   engine result and infinity flag, valid with op_done
//   op_done             engine completion pulse
module scalar_mult7 #(
  parameter int unsigned K_WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [K_WIDTH-1:0] scalar,
  input  logic [13:0]        point,
  output logic               busy,
  output logic               done,
  output logic [13:0]        result,
  output logic               result_inf,
  output logic               op_load,
  output logic               op_sel,
  output logic [13:0]        op_a,
  output logic [13:0]        op_b,
  input  logic [13:0]        op_result,
  input  logic               op_inf,
  input  logic               op_done
);

  localparam int unsigned IDX_W = $clog2(K_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL_ISSUE,
    S_DBL_WAIT,
    S_ADD_CHECK,
    S_ADD_ISSUE,
    S_ADD_WAIT,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [13:0]        p_q, p_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [13:0]        acc_q, acc_d;
  logic               acc_inf_q, acc_inf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               add_as_dbl_q, add_as_dbl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [13:0]        result_q, result_d;
  logic               result_inf_q, result_inf_d;
  logic               op_sel_q, op_sel_d;
  logic [13:0]        op_a_q, op_a_d;
  logic [13:0]        op_b_q, op_b_d;

  logic [K_WIDTH-1:0] k_shift;
  logic               k_bit;
  state_t             adv_state;
  logic [IDX_W-1:0]   adv_idx;

  // Current scalar bit without a variable part-select on a narrower index.
  assign k_shift = k_q >> idx_q;
  assign k_bit   = k_shift[0];

  // Shared "advance" step: finish after bit 0, otherwise scan the next bit.
  always_comb begin
    if (idx_q == '0) begin
      adv_state = S_FIN;
      adv_idx   = idx_q;
    end else begin
      adv_state = S_SCAN;
      adv_idx   = idx_q - IDX_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    k_d          = k_q;
    acc_d        = acc_q;
    acc_inf_d    = acc_inf_q;
    idx_d        = idx_q;
    add_as_dbl_d = add_as_dbl_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    result_d     = result_q;
    result_inf_d = result_inf_q;
    op_sel_d     = op_sel_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_load      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d       = point;
          k_d       = scalar;
          acc_inf_d = 1'b1;
          idx_d     = IDX_W'(K_WIDTH - 1);
          busy_d    = 1'b1;
          state_d   = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!acc_inf_q) begin
          op_sel_d     = 1'b0;
          op_a_d       = acc_q;
          add_as_dbl_d = 1'b0;
          state_d      = S_DBL_ISSUE;
        end else begin
          // Doubling infinity is infinity: only a set bit changes acc.
          if (k_bit) begin
            acc_d     = p_q;
            acc_inf_d = 1'b0;
          end
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end

      S_DBL_ISSUE: begin
        op_load = 1'b1;
        state_d = S_DBL_WAIT;
      end

      S_DBL_WAIT: begin
        if (op_done) begin
          acc_d     = op_result;
          acc_inf_d = op_inf;
          // A doubling that stood in for acc + P already consumed this bit.
          if (k_bit && !add_as_dbl_q) begin
            state_d = S_ADD_CHECK;
          end else begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end
      end

      S_ADD_CHECK: begin
        if (acc_inf_q) begin
          acc_d     = p_q;
          acc_inf_d = 1'b0;
          state_d   = adv_state;
          idx_d     = adv_idx;
        end else if (acc_q == p_q) begin
          // acc + P with acc == P is a doubling; the add formula is undefined.
          op_sel_d     = 1'b0;
          op_a_d       = acc_q;
          add_as_dbl_d = 1'b1;
          state_d      = S_DBL_ISSUE;
        end else if (acc_q[6:0] == p_q[6:0]) begin
          // Same x, different y: acc = -P = (x, x^y), so the sum is infinity.
          acc_inf_d = 1'b1;
          state_d   = adv_state;
          idx_d     = adv_idx;
        end else begin
          op_sel_d = 1'b1;
          op_a_d   = acc_q;
          op_b_d   = p_q;
          state_d  = S_ADD_ISSUE;
        end
      end

      S_ADD_ISSUE: begin
        op_load = 1'b1;
        state_d = S_ADD_WAIT;
      end

      S_ADD_WAIT: begin
        if (op_done) begin
          acc_d     = op_result;
          acc_inf_d = op_inf;
          state_d   = adv_state;
          idx_d     = adv_idx;
        end
      end

      S_FIN: begin
        result_d     = acc_q;
        result_inf_d = acc_inf_q;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      p_q          <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      acc_inf_q    <= 1'b0;
      idx_q        <= '0;
      add_as_dbl_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      result_inf_q <= 1'b0;
      op_sel_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      acc_inf_q    <= acc_inf_d;
      idx_q        <= idx_d;
      add_as_dbl_q <= add_as_dbl_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      result_inf_q <= result_inf_d;
      op_sel_q     <= op_sel_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign result_inf = result_inf_q;
  assign op_sel     = op_sel_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;

endmodule
